// File: rtl/axis_gen_pkg.sv
// Shared definitions for the AXI-Stream frame generator: pattern modes,
// FSM states and the Galois LFSR step.
package axis_gen_pkg;

    localparam logic [1:0] MODE_RAMP_FRAME = 2'd0;
    localparam logic [1:0] MODE_CONST      = 2'd1;
    localparam logic [1:0] MODE_LFSR       = 2'd2;
    localparam logic [1:0] MODE_RAMP_CONT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_FIN
    } gen_state_t;

    localparam int          LFSR_W    = 32;
    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/axis_gen_lfsr.sv
// 32-bit Galois LFSR; advances one step per cycle that step is high.
module axis_gen_lfsr
    import axis_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= SEED;
        end else if (step) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/axis_frame_generator.sv
// Programmable AXI-Stream frame source: N frames of L beats with selectable
// data pattern, optional inter-frame gap, full backpressure and clean abort.
module axis_frame_generator
    import axis_gen_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          LEN_WIDTH   = 16,
    parameter int          COUNT_WIDTH = 16,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_WIDTH-1:0]    frame_len,
    input  logic [COUNT_WIDTH-1:0]  frame_count,
    input  logic [1:0]              mode,
    input  logic [DATA_WIDTH-1:0]   pattern,
    input  logic [7:0]              gap_cycles,
    output logic                    m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  frames_sent,
    output logic [31:0]             beats_sent
);

    localparam int STRB_W = DATA_WIDTH / 8;

    gen_state_t             r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_len_m1, r_idx, w_idx_inc;
    logic [COUNT_WIDTH-1:0] r_count, r_frames, w_frames_inc;
    logic [1:0]             r_mode;
    logic [DATA_WIDTH-1:0]  r_pattern, r_tdata;
    logic [7:0]             r_gap, r_gap_cnt;
    logic [31:0]            r_beats, w_beats_inc;
    logic [STRB_W-1:0]      r_tstrb;
    logic                   r_abort, r_tvalid, r_tlast, r_busy, r_done;
    logic [LFSR_W-1:0]      w_lfsr, w_lfsr_nxt;
    logic                   w_launch, w_empty, w_hs, w_last_hs, w_more;
    logic                   w_abort_pend, w_tvalid_nxt, w_lfsr_step;

    function automatic logic [DATA_WIDTH-1:0] sel_data(
        input logic [1:0]            sel,
        input logic [LEN_WIDTH-1:0]  idx,
        input logic [DATA_WIDTH-1:0] pat,
        input logic [LFSR_W-1:0]     lfsr,
        input logic [31:0]           beats
    );
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        case (sel)
            MODE_RAMP_FRAME: v = DATA_WIDTH'(idx);
            MODE_CONST:      v = pat;
            MODE_LFSR: begin
                for (int k = 0; k < DATA_WIDTH; k++) v[k] = lfsr[k % LFSR_W];
            end
            default:         v = DATA_WIDTH'(beats);
        endcase
        return v;
    endfunction

    axis_gen_lfsr #(.SEED(SEED)) u_lfsr (
        .aclk   (aclk),
        .areset (areset),
        .step   (w_lfsr_step),
        .state  (w_lfsr)
    );

    assign w_hs         = r_tvalid & m_axis_tready;
    assign w_last_hs    = w_hs & r_tlast;
    assign w_abort_pend = r_abort | abort;
    assign w_frames_inc = r_frames + COUNT_WIDTH'(1);
    assign w_more       = w_frames_inc < r_count;
    assign w_idx_inc    = r_idx + LEN_WIDTH'(1);
    assign w_beats_inc  = r_beats + 32'd1;
    assign w_lfsr_nxt   = lfsr_step(w_lfsr);
    // A start coinciding with the done pulse must not relaunch
    assign w_launch     = (r_state == ST_IDLE) & start & ~r_done;
    assign w_empty      = (frame_len == '0) | (frame_count == '0);
    assign w_lfsr_step  = w_hs & (r_mode == MODE_LFSR);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tvalid_nxt = r_tvalid;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt  = w_empty ? ST_FIN : ST_SEND;
                    w_tvalid_nxt = ~w_empty;
                end
            end
            ST_SEND: begin
                if (w_last_hs) begin
                    if (w_more && !w_abort_pend) begin
                        if (r_gap != 8'd0) begin
                            w_state_nxt  = ST_GAP;
                            w_tvalid_nxt = 1'b0;
                        end
                    end else begin
                        w_state_nxt  = ST_FIN;
                        w_tvalid_nxt = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (w_abort_pend) begin
                    w_state_nxt = ST_FIN;
                end else if (r_gap_cnt == 8'd1) begin
                    w_state_nxt  = ST_SEND;
                    w_tvalid_nxt = 1'b1;
                end
            end
            ST_FIN: begin
                w_state_nxt  = ST_IDLE;
                w_tvalid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_tvalid_nxt = 1'b0;
            end
        endcase
    end

    // Run configuration: only meaningful once launched, so no reset
    always_ff @(posedge aclk) begin
        if (w_launch) begin
            r_len_m1  <= frame_len - LEN_WIDTH'(1);
            r_count   <= frame_count;
            r_mode    <= mode;
            r_pattern <= pattern;
            r_gap     <= gap_cycles;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_tvalid  <= 1'b0;
            r_tstrb   <= '0;
            r_tdata   <= '0;
            r_tlast   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_frames  <= '0;
            r_beats   <= '0;
            r_idx     <= '0;
            r_abort   <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_tvalid <= w_tvalid_nxt;
            r_tstrb  <= {STRB_W{w_tvalid_nxt}};
            r_done   <= (r_state == ST_FIN);

            if (w_launch) begin
                r_busy   <= 1'b1;
                r_frames <= '0;
                r_beats  <= '0;
                r_idx    <= '0;
                r_abort  <= 1'b0;
                r_tlast  <= (frame_len == LEN_WIDTH'(1));
                r_tdata  <= sel_data(mode, '0, pattern, w_lfsr, 32'd0);
            end else if (r_state == ST_FIN) begin
                r_busy  <= 1'b0;
                r_abort <= 1'b0;
            end else begin
                if (abort && (r_state inside {ST_SEND, ST_GAP})) r_abort <= 1'b1;
                if (w_hs) begin
                    r_beats <= w_beats_inc;
                    if (r_tlast) begin
                        r_idx    <= '0;
                        r_frames <= w_frames_inc;
                        r_tlast  <= (r_len_m1 == '0);
                        r_tdata  <= sel_data(r_mode, '0, r_pattern, w_lfsr_nxt, w_beats_inc);
                    end else begin
                        r_idx    <= w_idx_inc;
                        r_tlast  <= (w_idx_inc == r_len_m1);
                        r_tdata  <= sel_data(r_mode, w_idx_inc, r_pattern, w_lfsr_nxt, w_beats_inc);
                    end
                end
            end

            // Gap counter is armed on every frame end and counts down only in GAP
            if (w_last_hs)              r_gap_cnt <= r_gap;
            else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tstrb  = r_tstrb;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign frames_sent   = r_frames;
    assign beats_sent    = r_beats;

endmodule

// File: tb/tb_axis_frame_generator.sv
// Directed bench for axis_frame_generator: ramp, backpressure, gap, abort,
// empty runs, LFSR sequence and asynchronous reset.
module tb_axis_frame_generator;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] frame_len = '0;
    logic [15:0] frame_count = '0;
    logic [1:0]  mode = '0;
    logic [31:0] pattern = '0;
    logic [7:0]  gap_cycles = '0;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tstrb;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;
    logic [31:0] beats_sent;

    int checks = 0;
    int failures = 0;

    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_idle[$];
    int          strb_bad;

    axis_frame_generator dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .abort         (abort),
        .frame_len     (frame_len),
        .frame_count   (frame_count),
        .mode          (mode),
        .pattern       (pattern),
        .gap_cycles    (gap_cycles),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent),
        .beats_sent    (beats_sent)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] len, input logic [15:0] cnt,
                             input logic [1:0] md, input logic [31:0] pat, input logic [7:0] gap);
        frame_len   = len;
        frame_count = cnt;
        mode        = md;
        pattern     = pat;
        gap_cycles  = gap;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Drives tready, records handshaked beats and idle runs until done.
    task automatic collect(input int budget, input int abort_at, input logic [31:0] rpat,
                           input bit use_rpat);
        bit          stall_prev;
        bit          done_seen;
        logic [31:0] d_prev;
        logic        l_prev;
        int          idle_run;
        q_data.delete();
        q_last.delete();
        q_idle.delete();
        strb_bad   = 0;
        stall_prev = 1'b0;
        done_seen  = 1'b0;
        idle_run   = 0;
        d_prev     = '0;
        l_prev     = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            m_axis_tready = use_rpat ? rpat[cyc % 32] : 1'b1;
            if (stall_prev) begin
                check("stall_tvalid", m_axis_tvalid, 1'b1);
                check("stall_tdata", m_axis_tdata, d_prev);
                check("stall_tlast", m_axis_tlast, l_prev);
            end
            if (m_axis_tvalid && m_axis_tstrb != 4'hF) strb_bad++;
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_last.push_back(m_axis_tlast);
                q_idle.push_back(idle_run);
                idle_run = 0;
                if (abort_at >= 0 && q_data.size() == abort_at) abort = 1'b1;
            end else if (!m_axis_tvalid) begin
                idle_run++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            d_prev     = m_axis_tdata;
            l_prev     = m_axis_tlast;
            tick();
            abort = 1'b0;
        end
        m_axis_tready = 1'b1;
        check("done_seen", done_seen, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("tstrb_errs", strb_bad, 0);
    endtask

    initial begin
        int          errs_d;
        int          errs_l;
        logic [31:0] lfsr_exp[5];

        lfsr_exp[0] = 32'h0000_0001;
        lfsr_exp[1] = 32'h8020_0003;
        lfsr_exp[2] = 32'hC030_0002;
        lfsr_exp[3] = 32'h6018_0001;
        lfsr_exp[4] = 32'hB02C_0003;

        // Reset state
        tick();
        tick();
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tstrb", m_axis_tstrb, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_frames", frames_sent, 16'h0);
        check("rst_beats", beats_sent, 32'h0);
        areset = 1'b0;
        tick();

        // LFSR from reset seed
        start_run(16'd5, 16'd1, 2'd2, 32'h0, 8'd0);
        check("lfsr_busy_latency", busy, 1'b1);
        check("lfsr_tvalid_latency", m_axis_tvalid, 1'b1);
        collect(50, -1, 32'h0, 1'b0);
        check("lfsr_beats", q_data.size(), 5);
        for (int i = 0; i < 5 && i < q_data.size(); i++) check("lfsr_word", q_data[i], lfsr_exp[i]);
        check("lfsr_tlast", q_last[4], 1'b1);
        tick();

        // Basic ramp, back-to-back frames
        start_run(16'd451, 16'd3, 2'd0, 32'h0, 8'd0);
        collect(2000, -1, 32'h0, 1'b0);
        check("ramp_beats", q_data.size(), 1353);
        errs_d = 0;
        errs_l = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] !== 32'(i % 451)) errs_d++;
            if (q_last[i] !== ((i % 451) == 450)) errs_l++;
        end
        check("ramp_data_errs", errs_d, 0);
        check("ramp_tlast_errs", errs_l, 0);
        if (q_idle.size() == 1353) begin
            check("ramp_b2b_f2", q_idle[451], 0);
            check("ramp_b2b_f3", q_idle[902], 0);
        end
        check("ramp_frames", frames_sent, 16'd3);
        check("ramp_beats_sent", beats_sent, 32'd1353);
        tick();
        check("ramp_done_single", done, 1'b0);

        // Backpressure, continuous ramp
        start_run(16'd4, 16'd2, 2'd3, 32'h0, 8'd0);
        collect(200, -1, 32'hB5A3_6C4D, 1'b1);
        check("bp_beats", q_data.size(), 8);
        errs_d = 0;
        errs_l = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] !== 32'(i)) errs_d++;
            if (q_last[i] !== (i == 3 || i == 7)) errs_l++;
        end
        check("bp_data_errs", errs_d, 0);
        check("bp_tlast_errs", errs_l, 0);
        check("bp_frames", frames_sent, 16'd2);
        tick();

        // Inter-frame gap, constant pattern
        start_run(16'd2, 16'd3, 2'd1, 32'hDEAD_BEEF, 8'd5);
        collect(200, -1, 32'h0, 1'b0);
        check("gap_beats", q_data.size(), 6);
        errs_d = 0;
        for (int i = 0; i < q_data.size(); i++) if (q_data[i] !== 32'hDEAD_BEEF) errs_d++;
        check("gap_data_errs", errs_d, 0);
        if (q_idle.size() == 6) begin
            check("gap_idle_1", q_idle[2], 5);
            check("gap_idle_2", q_idle[4], 5);
            check("gap_in_frame", q_idle[3], 0);
        end
        check("gap_frames", frames_sent, 16'd3);
        tick();

        // Abort mid frame 2
        start_run(16'd8, 16'd10, 2'd0, 32'h0, 8'd0);
        collect(500, 11, 32'h0, 1'b0);
        check("abort_beats", q_data.size(), 16);
        if (q_data.size() == 16) begin
            check("abort_tlast_f2", q_last[15], 1'b1);
            check("abort_last_data", q_data[15], 32'd7);
        end
        check("abort_frames", frames_sent, 16'd2);
        check("abort_beats_sent", beats_sent, 32'd16);
        tick();

        // Empty runs and start ignored during done
        start_run(16'd0, 16'd5, 2'd0, 32'h0, 8'd0);
        check("len0_busy", busy, 1'b1);
        check("len0_tvalid", m_axis_tvalid, 1'b0);
        check("len0_done_early", done, 1'b0);
        tick();
        check("len0_done", done, 1'b1);
        check("len0_busy_drop", busy, 1'b0);
        check("len0_beats", beats_sent, 32'd0);
        start_run(16'd3, 16'd1, 2'd0, 32'h0, 8'd0);
        check("start_at_done_busy", busy, 1'b0);
        check("start_at_done_tvalid", m_axis_tvalid, 1'b0);
        tick();
        start_run(16'd4, 16'd0, 2'd0, 32'h0, 8'd0);
        check("cnt0_tvalid", m_axis_tvalid, 1'b0);
        tick();
        check("cnt0_done", done, 1'b1);
        check("cnt0_frames", frames_sent, 16'd0);
        tick();

        // Asynchronous reset mid-frame
        start_run(16'd100, 16'd1, 2'd0, 32'h0, 8'd0);
        tick();
        tick();
        check("arst_pre_tvalid", m_axis_tvalid, 1'b1);
        areset = 1'b1;
        #1;
        check("arst_tvalid", m_axis_tvalid, 1'b0);
        check("arst_tdata", m_axis_tdata, 32'h0);
        check("arst_busy", busy, 1'b0);
        check("arst_beats", beats_sent, 32'h0);
        tick();
        areset = 1'b0;
        tick();
        tick();
        check("arst_idle_tvalid", m_axis_tvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
